updown_counter_mod: RTL and testbench

//  Parametrised up/down counter; next generation of the team's 8-bit load/clear counter.

---
 rtl/updown_counter_if.sv | 26 ++
 rtl/updown_counter_mod.sv | 71 +++++++
 tb/tb_updown_counter_mod.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/updown_counter_if.sv
// Control/status bundle for updown_counter_mod: the master drives the count
// controls, the slave (the counter) returns the count and its flags.
interface updown_counter_if #(
    parameter int WIDTH = 8
);
    logic             clear;
    logic             load;
    logic [WIDTH-1:0] datain;
    logic             counten;
    logic             inc;
    logic [WIDTH-1:0] out;
    logic             tc;
    logic             ovf;
    logic             at_max;
    logic             at_min;

    modport master (
        output clear, load, datain, counten, inc,
        input  out, tc, ovf, at_max, at_min
    );

    modport slave (
        input  clear, load, datain, counten, inc,
        output out, tc, ovf, at_max, at_min
    );
endinterface

// File: rtl/updown_counter_mod.sv
// Parametrised up/down counter with programmable modulus, wrap/saturate mode,
// registered terminal-count pulse and sticky overflow flag.
module updown_counter_mod #(
    parameter int          WIDTH    = 8,
    parameter int unsigned MAX_VAL  = (2**WIDTH) - 1,
    parameter int          SATURATE = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    updown_counter_if.slave   bus
);
    localparam logic [WIDTH-1:0] MAXV = WIDTH'(MAX_VAL);

    logic [WIDTH-1:0] r_cnt;
    logic             r_tc;
    logic             r_ovf;

    logic             w_at_max;
    logic             w_at_min;
    logic             w_bnd;
    logic [WIDTH-1:0] w_ld_val;
    logic [WIDTH-1:0] w_cnt_nxt;

    assign w_at_max = (r_cnt == MAXV);
    assign w_at_min = (r_cnt == '0);

    // A boundary event is an enabled step that runs into the bound in the
    // current direction, regardless of whether the counter wraps or holds.
    assign w_bnd    = bus.counten & (bus.inc ? w_at_max : w_at_min);

    assign w_ld_val = (bus.datain > MAXV) ? MAXV : bus.datain;

    always_comb begin
        w_cnt_nxt = r_cnt;
        if (bus.inc) begin
            if (w_at_max) w_cnt_nxt = (SATURATE != 0) ? MAXV : '0;
            else          w_cnt_nxt = r_cnt + WIDTH'(1);
        end else begin
            if (w_at_min) w_cnt_nxt = (SATURATE != 0) ? '0 : MAXV;
            else          w_cnt_nxt = r_cnt - WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
            r_tc  <= 1'b0;
            r_ovf <= 1'b0;
        end else if (bus.clear) begin
            r_cnt <= '0;
            r_tc  <= 1'b0;
            r_ovf <= 1'b0;
        end else if (bus.load) begin
            r_cnt <= w_ld_val;
            r_tc  <= 1'b0;
            r_ovf <= 1'b0;
        end else if (bus.counten) begin
            r_cnt <= w_cnt_nxt;
            r_tc  <= w_bnd;
            r_ovf <= r_ovf | w_bnd;
        end else begin
            r_tc  <= 1'b0;
        end
    end

    assign bus.out    = r_cnt;
    assign bus.tc     = r_tc;
    assign bus.ovf    = r_ovf;
    assign bus.at_max = w_at_max;
    assign bus.at_min = w_at_min;
endmodule

// File: tb/tb_updown_counter_mod.sv
// Directed bench for updown_counter_mod: modulus-10 wrap, modulus-10 saturate
// and full-range 8-bit instances share one clock and reset.
module tb_updown_counter_mod;
    logic clk;
    logic rst_n;
    int   n_chk;
    int   n_fail;

    updown_counter_if #(.WIDTH(8)) bw ();
    updown_counter_if #(.WIDTH(8)) bs ();
    updown_counter_if #(.WIDTH(8)) bd ();

    updown_counter_mod #(.WIDTH(8), .MAX_VAL(9), .SATURATE(0)) u_wrap (
        .clk(clk), .rst_n(rst_n), .bus(bw.slave));
    updown_counter_mod #(.WIDTH(8), .MAX_VAL(9), .SATURATE(1)) u_sat (
        .clk(clk), .rst_n(rst_n), .bus(bs.slave));
    updown_counter_mod #(.WIDTH(8)) u_def (
        .clk(clk), .rst_n(rst_n), .bus(bd.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Advance one edge and sample 1ns later; inputs change only after sampling.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        rst_n  = 1'b0;
        {bw.clear, bw.load, bw.counten, bw.inc} = '0; bw.datain = '0;
        {bs.clear, bs.load, bs.counten, bs.inc} = '0; bs.datain = '0;
        {bd.clear, bd.load, bd.counten, bd.inc} = '0; bd.datain = '0;

        // reset state
        step(); step();
        chk("rst_out_d",   32'(bd.out), 32'h0);
        chk("rst_tc_d",    32'(bd.tc),  32'h0);
        chk("rst_ovf_d",   32'(bd.ovf), 32'h0);
        chk("rst_atmin_w", 32'(bw.at_min), 32'h1);
        rst_n = 1'b1;

        // async reset mid-count
        bd.load = 1'b1; bd.datain = 8'h29;
        step();
        bd.load = 1'b0; bd.counten = 1'b1; bd.inc = 1'b1;
        step();
        chk("pre_rst_out", 32'(bd.out), 32'h2A);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_out", 32'(bd.out), 32'h0);
        chk("async_rst_tc",  32'(bd.tc),  32'h0);
        chk("async_rst_ovf", 32'(bd.ovf), 32'h0);
        step();
        chk("held_rst_out", 32'(bd.out), 32'h0);
        rst_n = 1'b1;
        step();
        chk("resume_out", 32'(bd.out), 32'h1);
        bd.counten = 1'b0;

        // modulus-10 wrap up-count
        bw.counten = 1'b1; bw.inc = 1'b1;
        for (int i = 1; i <= 9; i++) begin
            step();
            chk("wrap_up_out", 32'(bw.out), 32'(i));
            chk("wrap_up_tc",  32'(bw.tc),  32'h0);
        end
        chk("wrap_atmax", 32'(bw.at_max), 32'h1);
        step();
        chk("wrap_0_out", 32'(bw.out), 32'h0);
        chk("wrap_0_tc",  32'(bw.tc),  32'h1);
        chk("wrap_0_ovf", 32'(bw.ovf), 32'h1);
        step();
        chk("wrap_1_out", 32'(bw.out), 32'h1);
        chk("wrap_1_tc",  32'(bw.tc),  32'h0);
        chk("wrap_1_ovf", 32'(bw.ovf), 32'h1);
        bw.clear = 1'b1;
        step();
        chk("clr_ovf_out", 32'(bw.out), 32'h0);
        chk("clr_ovf",     32'(bw.ovf), 32'h0);
        bw.clear = 1'b0; bw.counten = 1'b0;

        // modulus-10 saturate down-count from 2
        bs.load = 1'b1; bs.datain = 8'h2;
        step();
        chk("sat_ld_out", 32'(bs.out), 32'h2);
        bs.load = 1'b0; bs.counten = 1'b1; bs.inc = 1'b0;
        step();
        chk("sat_dn1_out", 32'(bs.out), 32'h1);
        step();
        chk("sat_dn0_out", 32'(bs.out), 32'h0);
        chk("sat_dn0_tc",  32'(bs.tc),  32'h0);
        step();
        chk("sat_hold1_out", 32'(bs.out), 32'h0);
        chk("sat_hold1_tc",  32'(bs.tc),  32'h1);
        chk("sat_hold1_ovf", 32'(bs.ovf), 32'h1);
        chk("sat_atmin",     32'(bs.at_min), 32'h1);
        step();
        chk("sat_hold2_tc",  32'(bs.tc),  32'h1);
        bs.counten = 1'b0;
        step();
        chk("sat_idle_tc",  32'(bs.tc),  32'h0);
        chk("sat_idle_ovf", 32'(bs.ovf), 32'h1);

        // load clamps to MAX_VAL, then saturate at top
        bs.load = 1'b1; bs.counten = 1'b1; bs.datain = 8'h6C;
        step();
        chk("clamp_out",   32'(bs.out),    32'h9);
        chk("clamp_atmax", 32'(bs.at_max), 32'h1);
        chk("clamp_ovf",   32'(bs.ovf),    32'h0);
        bs.load = 1'b0; bs.inc = 1'b1;
        step();
        chk("sat_top_out", 32'(bs.out), 32'h9);
        chk("sat_top_tc",  32'(bs.tc),  32'h1);
        bs.counten = 1'b0;

        // full-range wrap both directions
        bd.load = 1'b1; bd.datain = 8'hFF;
        step();
        chk("def_ld_ff", 32'(bd.out), 32'hFF);
        bd.load = 1'b0; bd.counten = 1'b1; bd.inc = 1'b1;
        step();
        chk("def_up_out", 32'(bd.out), 32'h00);
        chk("def_up_tc",  32'(bd.tc),  32'h1);
        bd.inc = 1'b0;
        step();
        chk("def_dn_out", 32'(bd.out), 32'hFF);
        chk("def_dn_tc",  32'(bd.tc),  32'h1);
        bd.counten = 1'b0;
        step();
        chk("def_idle_out", 32'(bd.out), 32'hFF);
        chk("def_idle_tc",  32'(bd.tc),  32'h0);
        chk("def_idle_ovf", 32'(bd.ovf), 32'h1);

        // load beats counten and clears ovf
        bd.load = 1'b1; bd.counten = 1'b1; bd.inc = 1'b1; bd.datain = 8'h6C;
        step();
        chk("ld_pri_out", 32'(bd.out), 32'h6C);
        chk("ld_pri_ovf", 32'(bd.ovf), 32'h0);
        bd.counten = 1'b0; bd.datain = 8'h55;
        step();
        chk("ld_55", 32'(bd.out), 32'h55);

        // clear beats load
        bd.clear = 1'b1; bd.datain = 8'h33;
        step();
        chk("clr_pri_out", 32'(bd.out), 32'h0);
        chk("clr_pri_ovf", 32'(bd.ovf), 32'h0);
        bd.clear = 1'b0; bd.load = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
